// File: rtl/pair_deser_pkg.sv
// ---------------------------------------------------------------------------
// pair_deser_pkg
// Shared types and constants for the pair deserializer and its output buffer.
// Optional feature macro used elsewhere in this slice: PAIR_DESER_WORD_CNT_EN.
// ---------------------------------------------------------------------------
package pair_deser_pkg;

   // Deserializer control states; encodings are kept stable for debug tools.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALIGN = 2'd1,
      RUN   = 2'd2
   } state_e;

   // Level of the divided clock that marks the A-lane slot.
   localparam logic PHASE_A = 1'b1;

endpackage : pair_deser_pkg

// File: rtl/pair_out_buf.sv
// ---------------------------------------------------------------------------
// pair_out_buf
// One-entry valid/ready holding register for an A/B word pair.
// A completed pair is loaded when the slot is empty or is being drained in the
// same cycle; otherwise the pair is dropped and the sticky overflow flag is set.
// clr_err_i clears overflow, but a new drop in the same cycle wins.
// ---------------------------------------------------------------------------
module pair_out_buf
   import pair_deser_pkg::*;
#(
   parameter int WORD_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic [WORD_W-1:0] a_i,
   input  logic [WORD_W-1:0] b_i,
   input  logic              ready_i,
   input  logic              clr_err_i,
   output logic [WORD_W-1:0] a_word_o,
   output logic [WORD_W-1:0] b_word_o,
   output logic              valid_o,
   output logic              overflow_o
);

   logic [WORD_W-1:0] a_q, a_d;
   logic [WORD_W-1:0] b_q, b_d;
   logic              valid_q, valid_d;
   logic              ovf_q, ovf_d;
   logic              can_load;
   logic              drop;

   // Slot is free if it is empty or its current content leaves this cycle.
   assign can_load = !valid_q || ready_i;
   assign drop     = load_i && !can_load;

   // Next-state for the holding register and the sticky overflow flag.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no
      // path leaves a value unassigned and no latch is inferred.
      a_d     = a_q;
      b_d     = b_q;
      valid_d = valid_q;
      ovf_d   = ovf_q & ~clr_err_i;
      if (load_i && can_load) begin
         a_d     = a_i;
         b_d     = b_i;
         valid_d = 1'b1;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
      if (drop) begin
         ovf_d = 1'b1;
      end
   end

   // State registers; the held words stay stable while the slot is stalled.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block evaluation order.
      if (!reset) begin
         a_q     <= '0;
         b_q     <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign a_word_o   = a_q;
   assign b_word_o   = b_q;
   assign valid_o    = valid_q;
   assign overflow_o = ovf_q;

endmodule : pair_out_buf

// File: rtl/pair_deserializer.sv
// ---------------------------------------------------------------------------
// pair_deserializer
// Splits an interleaved A/B serial stream (A while phase_in=1, B while 0) back
// into two lanes, assembles WORD_W-bit words LSB first, and hands each pair to
// a one-entry valid/ready buffer.
// Inputs are registered once; all decisions use the registered copies.
// A completed pair is flagged in a register and loaded into the buffer on the
// following edge, so word_valid rises two edges after the last B bit is sampled.
// Optional build macro PAIR_DESER_WORD_CNT_EN adds the word_cnt output, a
// 16-bit wrapping count of accepted handshakes, cleared by clr_err.
// ---------------------------------------------------------------------------
module pair_deserializer
   import pair_deser_pkg::*;
#(
   parameter int WORD_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              phase_in,
   input  logic              din,
   input  logic              clr_err,
   input  logic              word_ready,
   output logic [WORD_W-1:0] a_word,
   output logic [WORD_W-1:0] b_word,
   output logic              word_valid,
   output logic              locked,
   output logic              phase_err,
`ifdef PAIR_DESER_WORD_CNT_EN
   output logic [15:0]       word_cnt,
`endif
   output logic              overflow
);

   // Input stage
   logic phase_q;
   logic din_q;

   // Control and assembly state
   state_e            state_q, state_d;
   logic              exp_q, exp_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] a_shift_q, a_shift_d;
   logic [WORD_W-1:0] b_shift_q, b_shift_d;
   logic              done_q, done_d;
   logic              perr_q, perr_d;
   logic              perr_set;

   // One-hot position of the bit currently being written in either lane.
   logic [WORD_W-1:0] bit_mask;
   logic              last_bit;

   assign bit_mask = WORD_W'(1) << cnt_q;
   assign last_bit = (cnt_q == CNT_W'(WORD_W - 1));

   // Register the serial inputs; one cycle of input latency by design.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_q <= 1'b0;
         din_q   <= 1'b0;
      end else begin
         phase_q <= phase_in;
         din_q   <= din;
      end
   end

   // Alignment FSM, lane steering, bit counter and word completion.
   always_comb begin
      state_d   = state_q;
      exp_d     = exp_q;
      cnt_d     = cnt_q;
      a_shift_d = a_shift_q;
      b_shift_d = b_shift_q;
      done_d    = 1'b0;
      perr_set  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (en) begin
               state_d = ALIGN;
            end
         end

         ALIGN: begin
            if (!en) begin
               state_d   = IDLE;
               cnt_d     = '0;
               a_shift_d = '0;
               b_shift_d = '0;
            end else if (phase_q == PHASE_A) begin
               // This A-slot becomes bit 0 of a fresh word pair.
               a_shift_d = WORD_W'(din_q);
               b_shift_d = '0;
               cnt_d     = '0;
               exp_d     = ~PHASE_A;
               state_d   = RUN;
            end
         end

         RUN: begin
            if (!en) begin
               state_d   = IDLE;
               cnt_d     = '0;
               a_shift_d = '0;
               b_shift_d = '0;
            end else if (phase_q != exp_q) begin
               // Lost the A/B cadence: drop the sample and the partial word.
               perr_set  = 1'b1;
               state_d   = ALIGN;
               cnt_d     = '0;
               a_shift_d = '0;
               b_shift_d = '0;
            end else if (exp_q == PHASE_A) begin
               a_shift_d = (a_shift_q & ~bit_mask) | (din_q ? bit_mask : '0);
               exp_d     = ~PHASE_A;
            end else begin
               b_shift_d = (b_shift_q & ~bit_mask) | (din_q ? bit_mask : '0);
               exp_d     = PHASE_A;
               if (last_bit) begin
                  done_d = 1'b1;
                  cnt_d  = '0;
               end else begin
                  cnt_d  = cnt_q + CNT_W'(1);
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sticky phase error: a new violation wins over a same-cycle clear.
   assign perr_d = (perr_q & ~clr_err) | perr_set;

   // Control and assembly registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         exp_q     <= PHASE_A;
         cnt_q     <= '0;
         a_shift_q <= '0;
         b_shift_q <= '0;
         done_q    <= 1'b0;
         perr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         exp_q     <= exp_d;
         cnt_q     <= cnt_d;
         a_shift_q <= a_shift_d;
         b_shift_q <= b_shift_d;
         done_q    <= done_d;
         perr_q    <= perr_d;
      end
   end

   // done_q marks the cycle in which the shift registers hold a full pair;
   // the buffer samples them on the same edge the next word begins writing.
   pair_out_buf #(
      .WORD_W (WORD_W)
   ) u_out_buf (
      .clk        (clk),
      .reset      (reset),
      .load_i     (done_q),
      .a_i        (a_shift_q),
      .b_i        (b_shift_q),
      .ready_i    (word_ready),
      .clr_err_i  (clr_err),
      .a_word_o   (a_word),
      .b_word_o   (b_word),
      .valid_o    (word_valid),
      .overflow_o (overflow)
   );

   assign locked    = (state_q == RUN);
   assign phase_err = perr_q;

`ifdef PAIR_DESER_WORD_CNT_EN
   logic [15:0] wcnt_q;

   // Accepted-handshake counter; a clear in the same cycle forces zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wcnt_q <= '0;
      end else if (clr_err) begin
         wcnt_q <= '0;
      end else if (word_valid && word_ready) begin
         wcnt_q <= wcnt_q + 16'd1;
      end
   end

   assign word_cnt = wcnt_q;
`endif

endmodule : pair_deserializer
